// File: rtl/sipo_pkg.sv
// sipo_pkg: shared receiver state encoding for the serial frame receiver
package sipo_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP} rx_state_t;
endpackage

// File: rtl/shift_reg_serial_in_par_out.sv
// shift_reg_serial_in_par_out: M-bit right shifter, bit_in enters MSB when shift=1; ports clk, reset, bit_in, shift, bus_out
module shift_reg_serial_in_par_out #(
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         shift,
  output logic [M-1:0] bus_out
);
  always_ff @(posedge clk) begin
    if (reset) bus_out <= '0;
    else if (shift) bus_out <= {bit_in, bus_out[M-1:1]};
  end
endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: start/M data/stop frame receiver with valid/ready output, frame_err pulse, sticky overrun; ports clk, reset, bit_in, sample, ready, clr_err, bus_out, valid, frame_err, overrun
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         sample,
  input  logic         ready,
  input  logic         clr_err,
  output logic [M-1:0] bus_out,
  output logic         valid,
  output logic         frame_err,
  output logic         overrun
);
  localparam int CW = $clog2(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [M-1:0]  sr;
  shift_reg_serial_in_par_out #(.M(M)) u_sr (
    .clk    (clk),
    .reset  (reset),
    .bit_in (bit_in),
    .shift  (sample && state == DATA),
    .bus_out(sr)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_out   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (clr_err) overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      if (sample) begin
        case (state)
          IDLE: if (!bit_in) begin
            state <= DATA;
            cnt   <= '0;
          end
          DATA: if (cnt == LAST) state <= STOP;
                else cnt <= cnt + CW'(1);
          STOP: begin
            state <= IDLE;
            if (!bit_in) frame_err <= 1'b1;
            else if (!valid || ready) begin
              bus_out <= sr;
              valid   <= 1'b1;
            end else overrun <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: table-driven and directed checks of sipo_frame_rx with M=5
module tb_sipo_frame_rx;
  localparam int M = 5;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         bit_in = 1'b1;
  logic         sample = 1'b0;
  logic         ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [M-1:0] bus_out;
  logic         valid;
  logic         frame_err;
  logic         overrun;
  int           n_chk = 0;
  int           n_fail = 0;
  typedef struct {
    logic [M-1:0] d;
    logic         stop;
    logic         rf;
    logic         rs;
    logic         clr;
    logic [M-1:0] eb;
    logic         ev;
    logic         efe;
    logic         eov;
  } vec_t;
  vec_t vecs[7];
  sipo_frame_rx #(.M(M)) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (bit_in),
    .sample   (sample),
    .ready    (ready),
    .clr_err  (clr_err),
    .bus_out  (bus_out),
    .valid    (valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [M-1:0] eb, input logic ev,
                         input logic efe, input logic eov);
    chk({nm, ".bus_out"}, 32'(bus_out), 32'(eb));
    chk({nm, ".valid"}, 32'(valid), 32'(ev));
    chk({nm, ".frame_err"}, 32'(frame_err), 32'(efe));
    chk({nm, ".overrun"}, 32'(overrun), 32'(eov));
  endtask
  task automatic send_frame(input logic [M-1:0] d, input logic stop, input logic rf,
                            input logic rs, input logic clr);
    logic [M+1:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < M + 2; i++) begin
      @(negedge clk);
      bit_in  = bits[i];
      sample  = 1'b1;
      ready   = (i == M + 1) ? rs : rf;
      clr_err = clr;
    end
    @(negedge clk);
    sample  = 1'b0;
    ready   = 1'b0;
    clr_err = 1'b0;
    bit_in  = 1'b1;
  endtask
  initial begin
    vecs[0] = '{5'b01101, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01101, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{5'b10011, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10011, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{5'b00111, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10011, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{5'b11100, 1'b1, 1'b0, 1'b0, 1'b1, 5'b10011, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{5'b11000, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10011, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{5'b00001, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{5'b01110, 1'b1, 1'b1, 1'b0, 1'b0, 5'b01110, 1'b1, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_all("reset", 5'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].rf, vecs[i].rs, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].eb, vecs[i].ev, vecs[i].efe, vecs[i].eov);
    end
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    chk_all("drain", 5'b01110, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ready = 1'b0;
    chk("ready_ignored.valid", 32'(valid), 32'd0);
    send_frame(5'b10101, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("bad_stop", 5'b01110, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bad_stop_pulse_end", 32'(frame_err), 32'd0);
    send_frame(5'b11111, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("after_bad", 5'b11111, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_in = 1'b1;
      sample = 1'b1;
      @(negedge clk);
    end
    sample = 1'b0;
    bit_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("idle_hold", 5'b11111, 1'b0, 1'b0, 1'b0);
    bit_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_in = (i == 2) ? 1'b1 : 1'b0;
      sample = 1'b1;
      @(negedge clk);
    end
    reset  = 1'b1;
    bit_in = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    sample = 1'b0;
    bit_in = 1'b1;
    chk_all("mid_reset", 5'b0, 1'b0, 1'b0, 1'b0);
    send_frame(5'b10100, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("post_reset", 5'b10100, 1'b1, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
